// File: rtl/multicycle_controller.sv
// ============================================================================
// Module   : multicycle_controller
// Purpose  : Moore FSM sequencer, ALU decode, NZCV flags and condition gating
//            for a multicycle ARM-subset datapath with a unified memory port.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUControl,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [3:0]  State
);

    // Encoding 9 is reserved and, like 11..15, falls back to FETCH.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd10
    } state_t;

    localparam logic [1:0] c_ALU_ADD = 2'b00;
    localparam logic [1:0] c_ALU_SUB = 2'b01;
    localparam logic [1:0] c_ALU_AND = 2'b10;
    localparam logic [1:0] c_ALU_ORR = 2'b11;

    state_t      r_state;
    state_t      w_next;
    logic        r_condex;
    logic [3:0]  r_flags;

    logic [3:0]  w_cond;
    logic [1:0]  w_op;
    logic [5:0]  w_funct;
    logic        w_rd15;
    logic        w_condex;
    logic [1:0]  w_aluop;
    logic        w_nowrite;
    logic        w_cmp;
    logic [1:0]  w_flagw;
    logic        w_exec;
    logic        w_pcw;
    logic        w_mw;
    logic        w_irw;
    logic        w_rw;
    logic        w_unused;

    assign w_cond   = Instr[31:28];
    assign w_op     = Instr[27:26];
    assign w_funct  = Instr[25:20];
    assign w_rd15   = (Instr[15:12] == 4'hF);
    assign w_unused = &{1'b0, Instr[19:16], Instr[11:0]};

    always_comb begin
        w_condex = 1'b0;
        case (w_cond)
            4'h0:    w_condex = r_flags[2];
            4'h1:    w_condex = ~r_flags[2];
            4'h2:    w_condex = r_flags[1];
            4'h3:    w_condex = ~r_flags[1];
            4'h4:    w_condex = r_flags[3];
            4'h5:    w_condex = ~r_flags[3];
            4'h6:    w_condex = r_flags[0];
            4'h7:    w_condex = ~r_flags[0];
            4'h8:    w_condex = r_flags[1] & ~r_flags[2];
            4'h9:    w_condex = ~r_flags[1] | r_flags[2];
            4'hA:    w_condex = (r_flags[3] == r_flags[0]);
            4'hB:    w_condex = (r_flags[3] != r_flags[0]);
            4'hC:    w_condex = ~r_flags[2] & (r_flags[3] == r_flags[0]);
            4'hD:    w_condex = r_flags[2] | (r_flags[3] != r_flags[0]);
            4'hE:    w_condex = 1'b1;
            default: w_condex = 1'b0;
        endcase
    end

    always_comb begin
        w_aluop   = c_ALU_ADD;
        w_nowrite = 1'b0;
        w_cmp     = 1'b0;
        case (w_funct[4:1])
            4'b0100: w_aluop = c_ALU_ADD;
            4'b0010: w_aluop = c_ALU_SUB;
            4'b0000: w_aluop = c_ALU_AND;
            4'b1100: w_aluop = c_ALU_ORR;
            4'b1010: begin
                w_aluop   = c_ALU_SUB;
                w_nowrite = 1'b1;
                w_cmp     = 1'b1;
            end
            default: begin
                w_aluop   = c_ALU_ADD;
                w_nowrite = 1'b1;
            end
        endcase
        w_flagw[1] = w_funct[0] | w_cmp;
        w_flagw[0] = (w_funct[0] & ((w_aluop == c_ALU_ADD) || (w_aluop == c_ALU_SUB))) | w_cmp;
    end

    assign w_exec = (r_state == S_EXECR) || (r_state == S_EXECI);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_FETCH;
            r_condex <= 1'b0;
            r_flags  <= 4'b0000;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_condex <= w_condex;
            end
            if (w_exec && r_condex) begin
                if (w_flagw[1]) r_flags[3:2] <= ALUFlags[3:2];
                if (w_flagw[0]) r_flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    always_comb begin
        w_next     = S_FETCH;
        w_pcw      = 1'b0;
        w_mw       = 1'b0;
        w_irw      = 1'b0;
        w_rw       = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = c_ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_irw     = 1'b1;
                w_pcw     = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                w_next    = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (w_op)
                    2'b01:   w_next = S_MEMADR;
                    2'b00:   w_next = w_funct[5] ? S_EXECI : S_EXECR;
                    2'b10:   w_next = S_BRANCH;
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
                w_next  = w_funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                w_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                w_rw      = r_condex;
                w_pcw     = r_condex & w_rd15;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                w_mw   = r_condex;
            end
            S_EXECR: begin
                ALUControl = w_aluop;
                w_next     = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = w_aluop;
                w_next     = S_ALUWB;
            end
            S_ALUWB: begin
                // A compare never writes back, so it cannot redirect the PC either.
                w_rw  = r_condex & ~w_nowrite;
                w_pcw = r_condex & ~w_nowrite & w_rd15;
            end
            S_BRANCH: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                w_pcw     = r_condex;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Architectural enables are held off combinationally for the whole reset window.
    assign PCWrite  = reset & w_pcw;
    assign MemWrite = reset & w_mw;
    assign IRWrite  = reset & w_irw;
    assign RegWrite = reset & w_rw;
    assign ImmSrc   = w_op;
    assign RegSrc   = {(w_op == 2'b01), (w_op == 2'b10)};
    assign State    = r_state;

endmodule

`default_nettype wire

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing controller for the multicycle variant of the ARM-subset datapath, where one unified memory port serves both instruction fetch and data access. Decodes the latched instruction fields, steps a Moore FSM through 3–5 cycles per instruction and drives every mux select and write enable in the datapath. Owns the NZCV flags register and conditional-execution logic. Every architectural write is gated by the instruction's condition code.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Instr  in  32  instruction register contents; uses Cond=[31:28], Op=[27:26], Funct=[25:20], Rd=[15:12].
- ALUFlags  in  4  {N,Z,C,V} from the ALU in the current cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result.
- MemWrite  out  1  data memory write enable.
- IRWrite  out  1  instruction register enable.
- RegWrite  out  1  register file write enable.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  ALU A select: 00 = RD1, 01 = PC, 10 = ALUOut.
- ALUSrcB  out  2  ALU B select: 00 = RD2, 01 = ExtImm, 10 = constant 4.
- ALUControl  out  2  ALU operation: 00 = ADD, 01 = SUB, 10 = AND, 11 = ORR.
- ImmSrc  out  2  extender mode; equals Op.
- RegSrc  out  2  [0] = (Op==10), selects R15 for RA1; [1] = (Op==01), selects Rd for RA2.
- State  out  4  current FSM state, for debug.

## Operation
**FSM states.** Encoding is 0..10 in the order listed. Each entry gives the outputs that are not 0, then the next state.
- FETCH: AdrSrc=0, IRWrite, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, PCWrite. Next: DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10. Next state by opcode:
  - Op=01 → MEMADR.
  - Op=00 and Funct[5]=0 → EXECR.
  - Op=00 and Funct[5]=1 → EXECI.
  - Op=10 → BRANCH.
  - Op=11 → FETCH (illegal opcode, no side effects).
- MEMADR: ALUSrcA=00, ALUSrcB=01, ADD. Next: MEMREAD if Funct[0]=1, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Next: MEMWB.
- MEMWB: ResultSrc=01, RegWrite gated. Next: FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite gated. Next: FETCH.
- EXECR: ALUSrcA=00, ALUSrcB=00, ALU decode active. Next: ALUWB.
- EXECI: ALUSrcA=00, ALUSrcB=01, ALU decode active. Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite gated unless NoWrite. Next: FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, ADD, PCWrite gated. Next: FETCH.
- Undefined encodings 11..15: next state is FETCH.

**ALU decode** (only in EXECR and EXECI; all other states force ADD), keyed on Funct[4:1]:
- 0100 → ADD.
- 0010 → SUB.
- 0000 → AND.
- 1100 → ORR.
- 1010 → CMP: SUB with NoWrite=1.
- Any other value → ADD with NoWrite=1.

**Flag-write enables.**
- FlagW[1] (N,Z) = Funct[0].
- FlagW[0] (C,V) = Funct[0] & (op is ADD or SUB).
- CMP always writes flags, regardless of Funct[0].

**Condition logic.**
- CondEx is evaluated from Cond against the flags register: EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V, HI C&~Z, LS ~C|Z, GE N==V, LT N!=V, GT ~Z&(N==V), LE Z|(N!=V), AL 1, 1111 → 0.
- CondEx is latched into condex_q at the end of DECODE. All later gating uses condex_q.
- Flags register updates at the end of EXECR/EXECI when condex_q=1, per FlagW bit:
  - NZ ← ALUFlags[3:2].
  - CV ← ALUFlags[1:0].
- Instructions with Rd=15:
  - In ALUWB or MEMWB, PCWrite is also asserted when condex_q=1 (PC write from result).
  - RegWrite stays asserted, matching the datapath's R15 handling.
- If condex_q=0, RegWrite, MemWrite, the flag update and PCWrite are suppressed. The FSM still walks the same states, so a squashed instruction costs the same cycles.

## Timing
- Reset low:
  - State=FETCH, flags=0000, condex_q=0.
  - PCWrite, IRWrite, MemWrite and RegWrite are forced to 0 combinationally while reset is low.
  - Release is asynchronous-assert, synchronous-deassert in effect: the first FETCH executes on the first rising edge after reset rises.
- Outputs are Moore decodes of state, except:
  - ALUControl depends on Funct.
  - Gated enables depend on condex_q.
  - ImmSrc and RegSrc depend on Op.
- Cycles per instruction:
  - Branch: 3.
  - Data-processing: 4.
  - STR: 4.
  - LDR: 5.
  - Illegal opcode: 2.
- Flags written in EXECx are visible to CondEx of the next instruction's DECODE.
- Reset asserted mid-instruction aborts it. No write enable may pulse after reset falls.

## Test plan
- Reset low for 3 cycles, then high:
  - State=0 and all enables 0 while low.
  - First edge gives IRWrite=1, PCWrite=1.
  - State sequence is 0→1.
- Instr=E0812003 (ADD R2,R1,R3), ALUFlags=0:
  - States 0,1,6,8,0.
  - RegWrite=1 only in ALUWB; ALUControl=00 in EXECR.
  - Flags stay 0000.
- Instr=E2510005 (SUBS R0,R1,#5), ALUFlags=0100 in EXECI, then Instr=0A000002 (BEQ):
  - Flags become 0100.
  - BEQ walks states 0,1,10,0 with PCWrite=1 in BRANCH.
- Same BEQ with flags=0000:
  - BRANCH has PCWrite=0.
  - Next FETCH proceeds normally.
- Instr=E5912004 (LDR): states 0,1,2,3,4,0 with AdrSrc=1 in MEMREAD and RegWrite=1 in MEMWB.
- Instr=E5812004 (STR): MemWrite=1 only in MEMWRITE.
- Instr=E1510002 (CMP): flags update in EXECR; RegWrite=0 in ALUWB.
- Reset pulsed low during MEMWRITE: MemWrite drops to 0 immediately and State=0.
